load_store_unit: RTL and testbench

Memory stage of the CPU, sitting directly upstream of memory_control_synth. It accepts one LOAD/STORE micro-op per handshake from execute and computes the effective address (base + imm). It then drives the memory controller's start/address/mode/write_enable/write_data, holds them stable until done, and returns the result and destination register to writeback. It also owns the fault checks: illegal funct3, timeout, and optional misalignment.

---
 rtl/load_store_unit.sv | 153 +++++++++++++++
 tb/tb_load_store_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory stage: computes base+imm, drives one controller access per micro-op, returns the result or fault to writeback.
// Optional macro MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of issuing them.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_base,
  input  logic [XLEN-1:0] req_imm,
  input  logic [XLEN-1:0] req_store_data,
  input  logic [4:0]      req_rd,
  output logic            mem_start,
  output logic [XLEN-1:0] mem_address,
  output logic [2:0]      mem_mode,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_write_data,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mem_read_data,
  input  logic            mem_active,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_we,
  output logic [4:0]      resp_rd,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault,
  output logic [1:0]      resp_cause
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t          state_reg;
  logic [7:0]      count_reg;
  logic            is_store_reg;
  logic            we_reg;
  logic [XLEN-1:0] addr_next;
  logic            funct3_legal;
  logic            misaligned;

  assign addr_next = req_base + req_imm;

  always_comb begin
    funct3_legal = 1'b0;
    if (req_is_store) begin
      funct3_legal = (req_funct3 <= 3'd2);
    end else begin
      case (req_funct3)
        3'd0, 3'd1, 3'd2, 3'd4, 3'd5: funct3_legal = 1'b1;
        default:                      funct3_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misaligned = addr_next[0];
      2'b10:   misaligned = |addr_next[1:0];
      default: misaligned = 1'b0;
    endcase
`endif
  end

  // Start and write-enable are gated by reset so they drop in the reset cycle itself.
  assign mem_start        = (state_reg == ISSUE) && !mem_active && !reset;
  assign mem_write_enable = we_reg && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      is_store_reg   <= 1'b0;
      we_reg         <= 1'b0;
      req_ready      <= 1'b1;
      mem_address    <= '0;
      mem_mode       <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_we        <= 1'b0;
      resp_rd        <= '0;
      resp_data      <= '0;
      resp_fault     <= 1'b0;
      resp_cause     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_ready      <= 1'b0;
            is_store_reg   <= req_is_store;
            mem_address    <= addr_next;
            mem_mode       <= req_funct3;
            mem_write_data <= req_store_data;
            resp_rd        <= req_rd;
            if (!funct3_legal || misaligned) begin
              state_reg  <= RESP;
              resp_valid <= 1'b1;
              resp_we    <= 1'b0;
              resp_data  <= '0;
              resp_fault <= 1'b1;
              resp_cause <= !funct3_legal ? 2'd1 : 2'd3;
            end else begin
              state_reg <= ISSUE;
              we_reg    <= req_is_store;
            end
          end
        end
        ISSUE: begin
          if (!mem_active) begin
            state_reg <= WAIT;
            count_reg <= '0;
          end
        end
        WAIT: begin
          if (mem_done) begin
            state_reg  <= RESP;
            we_reg     <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= !is_store_reg;
            resp_data  <= is_store_reg ? '0 : mem_read_data;
            resp_fault <= 1'b0;
            resp_cause <= 2'd0;
          end else if (count_reg == LAST_COUNT) begin
            state_reg  <= RESP;
            we_reg     <= 1'b0;
            resp_valid <= 1'b1;
            resp_we    <= 1'b0;
            resp_data  <= '0;
            resp_fault <= 1'b1;
            resp_cause <= 2'd2;
          end else begin
            count_reg <= count_reg + 8'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_reg  <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small latency-accurate controller model driven from the stimulus tasks.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_base, req_imm, req_store_data;
  logic [4:0]  req_rd;
  logic        mem_start;
  logic [31:0] mem_address;
  logic [2:0]  mem_mode;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_done;
  logic [31:0] mem_read_data;
  logic        mem_active;
  logic        resp_valid, resp_ready, resp_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_fault;
  logic [1:0]  resp_cause;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(15), .XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
    .req_store_data(req_store_data), .req_rd(req_rd),
    .mem_start(mem_start), .mem_address(mem_address), .mem_mode(mem_mode),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_done(mem_done), .mem_read_data(mem_read_data), .mem_active(mem_active),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rd(resp_rd), .resp_data(resp_data), .resp_fault(resp_fault),
    .resp_cause(resp_cause)
  );

  int n_checks = 0;
  int n_fails  = 0;

  int          start_cnt, start_cyc, resp_cyc, cyc;
  logic [31:0] o_addr, o_wdata, o_data;
  logic [2:0]  o_mode;
  logic        o_we, o_rwe, o_fault, we_stable;
  logic [1:0]  o_cause;
  logic [4:0]  o_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int ctrl_latency(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2;
      2'b01:   return 3;
      default: return 5;
    endcase
  endfunction

  // One micro-op: accept, model the controller (stall, done after N cycles), observe response, hold, release.
  task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                        input logic [31:0] base, input logic [31:0] imm, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input bit give_done, input int stall, input int hold);
    start_cnt = 0; start_cyc = -1; resp_cyc = -1; we_stable = 1'b1;
    o_addr = '0; o_mode = '0; o_we = 1'b0; o_wdata = '0;
    @(negedge clk);
    check({name, "_req_ready"}, 32'(req_ready), 32'd1);
    req_is_store = st; req_funct3 = f3; req_base = base; req_imm = imm;
    req_store_data = sdata; req_rd = rd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      mem_active = (cyc < stall);
      #1;
      if (mem_done) mem_read_data = 32'hBAD0BAD0;
      mem_done = 1'b0;
      if (mem_start) begin
        start_cnt++;
        if (start_cyc < 0) begin
          start_cyc = cyc; o_addr = mem_address; o_mode = mem_mode;
          o_we = mem_write_enable; o_wdata = mem_write_data;
        end
      end
      if (start_cyc >= 0 && !resp_valid && mem_write_enable !== st) we_stable = 1'b0;
      if (resp_valid) begin
        resp_cyc = cyc; o_rd = resp_rd; o_data = resp_data; o_rwe = resp_we;
        o_fault = resp_fault; o_cause = resp_cause;
        break;
      end
      if (give_done && start_cyc >= 0 && cyc == start_cyc + ctrl_latency(f3)) begin
        mem_done = 1'b1; mem_read_data = rdata;
      end
      @(negedge clk);
      cyc++;
    end
    if (resp_cyc < 0) check({name, "_resp_bound"}, 32'd0, 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check({name, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({name, "_hold_data"}, resp_data, o_data);
      check({name, "_hold_rd"}, 32'(resp_rd), 32'(o_rd));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    check({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    check({name, "_ready_back"}, 32'(req_ready), 32'd1);
    $display("txn %s: starts=%0d start_cyc=%0d resp_cyc=%0d addr=%08h mode=%0d we=%0d rd=%0d data=%08h rwe=%0d fault=%0d cause=%0d",
             name, start_cnt, start_cyc, resp_cyc, o_addr, o_mode, o_we, o_rd, o_data, o_rwe, o_fault, o_cause);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
    req_base = '0; req_imm = '0; req_store_data = '0; req_rd = '0;
    mem_done = 1'b0; mem_read_data = '0; mem_active = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_start", 32'(mem_start), 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_addr", mem_address, 32'd0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    reset = 1'b0;

    // LW 0x100+4, 5-cycle word access.
    run_op("lw", 1'b0, 3'b010, 32'h100, 32'd4, 32'h0, 5'd5, 32'hDEADBEEF, 1'b1, 0, 0);
    check("lw_starts", 32'(start_cnt), 32'd1);
    check("lw_addr", o_addr, 32'h104);
    check("lw_mode", 32'(o_mode), 32'd2);
    check("lw_mem_we", 32'(o_we), 32'd0);
    check("lw_rd", 32'(o_rd), 32'd5);
    check("lw_data", o_data, 32'hDEADBEEF);
    check("lw_resp_we", 32'(o_rwe), 32'd1);
    check("lw_fault", 32'(o_fault), 32'd0);
    check("lw_latency", 32'(resp_cyc), 32'd7);

    // SB 0x200-1: write held until done, no data returned.
    run_op("sb", 1'b1, 3'b000, 32'h200, 32'hFFFFFFFF, 32'h12345678, 5'd7, 32'hFFFFFFFF, 1'b1, 0, 0);
    check("sb_starts", 32'(start_cnt), 32'd1);
    check("sb_addr", o_addr, 32'h1FF);
    check("sb_mode", 32'(o_mode), 32'd0);
    check("sb_mem_we", 32'(o_we), 32'd1);
    check("sb_wdata", o_wdata, 32'h12345678);
    check("sb_we_stable", 32'(we_stable), 32'd1);
    check("sb_resp_we", 32'(o_rwe), 32'd0);
    check("sb_data", o_data, 32'd0);
    check("sb_latency", 32'(resp_cyc), 32'd4);

    // LBU: byte latency, data passed through untouched.
    run_op("lbu", 1'b0, 3'b100, 32'h0, 32'h33, 32'h0, 5'd9, 32'h000000A7, 1'b1, 0, 0);
    check("lbu_addr", o_addr, 32'h33);
    check("lbu_data", o_data, 32'h000000A7);
    check("lbu_latency", 32'(resp_cyc), 32'd4);

    // LW with no done: 15 WAIT cycles then timeout.
    run_op("lw_to", 1'b0, 3'b010, 32'h300, 32'd0, 32'h0, 5'd3, 32'h11111111, 1'b0, 0, 0);
    check("to_starts", 32'(start_cnt), 32'd1);
    check("to_wait_cycles", 32'(resp_cyc - start_cyc - 1), 32'd15);
    check("to_fault", 32'(o_fault), 32'd1);
    check("to_cause", 32'(o_cause), 32'd2);
    check("to_data", o_data, 32'd0);
    check("to_resp_we", 32'(o_rwe), 32'd0);

    // Illegal funct3: load 3, load 6, store 3.
    run_op("ld_f3", 1'b0, 3'b011, 32'h400, 32'd0, 32'h0, 5'd4, 32'h0, 1'b1, 0, 0);
    check("ld_f3_starts", 32'(start_cnt), 32'd0);
    check("ld_f3_fault", 32'(o_fault), 32'd1);
    check("ld_f3_cause", 32'(o_cause), 32'd1);
    check("ld_f3_latency", 32'(resp_cyc), 32'd1);
    run_op("l6_f3", 1'b0, 3'b110, 32'h400, 32'd0, 32'h0, 5'd4, 32'h0, 1'b1, 0, 0);
    check("l6_f3_cause", 32'(o_cause), 32'd1);
    run_op("sd_f3", 1'b1, 3'b011, 32'h400, 32'd0, 32'hFFFF, 5'd4, 32'h0, 1'b1, 0, 0);
    check("sd_f3_starts", 32'(start_cnt), 32'd0);
    check("sd_f3_cause", 32'(o_cause), 32'd1);
    check("sd_f3_resp_we", 32'(o_rwe), 32'd0);

    // LH at odd address.
    run_op("lh_odd", 1'b0, 3'b001, 32'h100, 32'd1, 32'h0, 5'd6, 32'hFFFF8001, 1'b1, 0, 0);
`ifdef MISALIGN_TRAP_EN
    check("lh_odd_starts", 32'(start_cnt), 32'd0);
    check("lh_odd_cause", 32'(o_cause), 32'd3);
    check("lh_odd_fault", 32'(o_fault), 32'd1);
`else
    check("lh_odd_starts", 32'(start_cnt), 32'd1);
    check("lh_odd_addr", o_addr, 32'h101);
    check("lh_odd_data", o_data, 32'hFFFF8001);
    check("lh_odd_latency", 32'(resp_cyc), 32'd5);
`endif

    // mem_done while idle is ignored.
    @(negedge clk);
    mem_done = 1'b1;
    @(negedge clk);
    mem_done = 1'b0;
    #1;
    check("idle_done_valid", 32'(resp_valid), 32'd0);
    check("idle_done_ready", 32'(req_ready), 32'd1);

    // Reset in the middle of a store: write enable drops in the reset cycle.
    @(negedge clk);
    req_is_store = 1'b1; req_funct3 = 3'b010; req_base = 32'h500; req_imm = 32'd0;
    req_store_data = 32'hCAFEF00D; req_rd = 5'd0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_we_before", 32'(mem_write_enable), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_we_drop", 32'(mem_write_enable), 32'd0);
    check("rst_mid_start", 32'(mem_start), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_valid", 32'(resp_valid), 32'd0);
    $display("txn rst_mid: reset applied during store WAIT");

    // Controller busy after reset; response held with resp_ready low.
    mem_active = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("busy_idle_start", 32'(mem_start), 32'd0);
    end
    run_op("lw_stall", 1'b0, 3'b010, 32'h600, 32'd8, 32'h0, 5'd12, 32'h5A5A1234, 1'b1, 3, 3);
    check("stall_starts", 32'(start_cnt), 32'd1);
    check("stall_start_cyc", 32'(start_cyc), 32'd3);
    check("stall_addr", o_addr, 32'h608);
    check("stall_data", o_data, 32'h5A5A1234);
    check("stall_rd", 32'(o_rd), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
